// File: rtl/axi_simple_mem_slave.sv
// Simple AXI memory slave: byte-addressable RAM behind independent INCR-only
// write (AW/W/B) and read (AR/R) state machines, one burst in flight per direction.
module axi_simple_mem_slave #(
  parameter int unsigned AXI_WIDTH_CID = 4,
  parameter int unsigned AXI_WIDTH_ID  = 4,
  parameter int unsigned AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID,
  parameter int unsigned AXI_WIDTH_AD  = 32,
  parameter int unsigned AXI_WIDTH_DA  = 32,
  parameter int unsigned AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
  parameter int unsigned ADDR_LENGTH   = 12
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_WIDTH_SID-1:0] S_AWID,
  input  logic [AXI_WIDTH_AD-1:0]  S_AWADDR,
  input  logic [7:0]               S_AWLEN,
  input  logic                     S_AWVALID,
  output logic                     S_AWREADY,
  input  logic [AXI_WIDTH_DA-1:0]  S_WDATA,
  input  logic [AXI_WIDTH_DS-1:0]  S_WSTRB,
  input  logic                     S_WLAST,
  input  logic                     S_WVALID,
  output logic                     S_WREADY,
  output logic [AXI_WIDTH_SID-1:0] S_BID,
  output logic [1:0]               S_BRESP,
  output logic                     S_BVALID,
  input  logic                     S_BREADY,
  input  logic [AXI_WIDTH_SID-1:0] S_ARID,
  input  logic [AXI_WIDTH_AD-1:0]  S_ARADDR,
  input  logic [7:0]               S_ARLEN,
  input  logic                     S_ARVALID,
  output logic                     S_ARREADY,
  output logic [AXI_WIDTH_SID-1:0] S_RID,
  output logic [AXI_WIDTH_DA-1:0]  S_RDATA,
  output logic [1:0]               S_RRESP,
  output logic                     S_RLAST,
  output logic                     S_RVALID,
  input  logic                     S_RREADY
);

  localparam int unsigned LANE_W = $clog2(AXI_WIDTH_DS);
  localparam int unsigned IDX_W  = ADDR_LENGTH - LANE_W;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Storage: word array, deliberately not reset
  logic [AXI_WIDTH_DA-1:0] mem_q [DEPTH];

  // Write channel state
  w_state_e                 w_state_q;
  logic                     aw_ready_q;
  logic                     w_ready_q;
  logic                     b_valid_q;
  logic [1:0]               b_resp_q;
  logic [AXI_WIDTH_SID-1:0] b_id_q;
  logic [IDX_W-1:0]         w_addr_q;
  logic [7:0]               w_len_q;
  logic [7:0]               w_cnt_q;
  logic                     w_err_q;

  // Read channel state
  r_state_e                 r_state_q;
  logic                     ar_ready_q;
  logic                     r_valid_q;
  logic                     r_last_q;
  logic [AXI_WIDTH_DA-1:0]  r_data_q;
  logic [AXI_WIDTH_SID-1:0] r_id_q;
  logic [IDX_W-1:0]         r_addr_q;
  logic [7:0]               r_len_q;
  logic [7:0]               r_cnt_q;

  logic             aw_fire_c;
  logic             w_fire_c;
  logic             w_last_beat_c;
  logic             w_err_c;
  logic             ar_fire_c;
  logic [IDX_W-1:0] ar_idx_c;

  assign aw_fire_c     = S_AWVALID & aw_ready_q;
  assign w_fire_c      = S_WVALID & w_ready_q;
  assign w_last_beat_c = (w_cnt_q == w_len_q);
  assign w_err_c       = w_err_q | (S_WLAST ^ w_last_beat_c);
  assign ar_fire_c     = S_ARVALID & ar_ready_q;
  assign ar_idx_c      = S_ARADDR[ADDR_LENGTH-1:LANE_W];

  // Address bits above the memory size and below the word lane are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AWADDR, S_ARADDR};

  // Write FSM: accept address, then LEN+1 data beats, then hold the response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      b_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= 8'd0;
      w_cnt_q    <= 8'd0;
      w_err_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (aw_fire_c) begin
            b_id_q     <= S_AWID;
            w_addr_q   <= S_AWADDR[ADDR_LENGTH-1:LANE_W];
            w_len_q    <= S_AWLEN;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            w_err_q <= w_err_c;
            if (w_last_beat_c) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= w_err_c ? 2'b10 : 2'b00;
              w_state_q <= W_RESP;
            end else begin
              w_addr_q <= w_addr_q + IDX_W'(1);
              w_cnt_q  <= w_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
        default: begin
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
          w_state_q  <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-lane memory write on every accepted W beat
  always_ff @(posedge ACLK) begin
    if (w_fire_c) begin
      for (int unsigned l = 0; l < AXI_WIDTH_DS; l++) begin
        if (S_WSTRB[l]) begin
          mem_q[w_addr_q][l*8 +: 8] <= S_WDATA[l*8 +: 8];
        end
      end
    end
  end

  // Read FSM: load first word on AR handshake, advance on each R handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= 8'd0;
      r_cnt_q    <= 8'd0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_fire_c) begin
            r_id_q     <= S_ARID;
            r_len_q    <= S_ARLEN;
            r_cnt_q    <= 8'd0;
            r_data_q   <= mem_q[ar_idx_c];
            r_addr_q   <= ar_idx_c + IDX_W'(1);
            r_last_q   <= (S_ARLEN == 8'd0);
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            r_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_RREADY) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= R_IDLE;
            end else begin
              r_data_q <= mem_q[r_addr_q];
              r_addr_q <= r_addr_q + IDX_W'(1);
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: begin
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
          r_state_q  <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AWREADY = aw_ready_q;
  assign S_WREADY  = w_ready_q;
  assign S_BVALID  = b_valid_q;
  assign S_BRESP   = b_resp_q;
  assign S_BID     = b_id_q;
  assign S_ARREADY = ar_ready_q;
  assign S_RVALID  = r_valid_q;
  assign S_RLAST   = r_last_q;
  assign S_RDATA   = r_data_q;
  assign S_RID     = r_id_q;
  assign S_RRESP   = 2'b00;

endmodule
